// File: rtl/stripes_pkg.sv
// Shared types, default widths and the sign-extension helper for the Stripes column accumulator.
package stripes_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int PSUM_WIDTH_DEF = DATA_WIDTH_DEF + 10;
  localparam int ACC_WIDTH_DEF  = DATA_WIDTH_DEF + 16;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

  // Sign-extend the low w bits of v to 64 bits; callers truncate to their own width.
  function automatic logic [63:0] sext(input logic [63:0] v, input int unsigned w);
    logic [63:0] s;
    s = v << (64 - w);
    return $signed(s) >>> (64 - w);
  endfunction

endpackage

// File: rtl/stripes_acc_add.sv
// Combinational accumulator adder with overflow detect.
// STRIPES_ACC_SAT_EN selects saturation instead of two's-complement wrap.
module stripes_acc_add #(
  parameter int ACC_WIDTH = 24
) (
  input  logic signed [ACC_WIDTH-1:0] a,
  input  logic signed [ACC_WIDTH-1:0] b,
  output logic signed [ACC_WIDTH-1:0] sum,
  output logic                        ovf
);

  logic signed [ACC_WIDTH-1:0] raw;

  always_comb begin
    raw = a + b;
    // Overflow only when both operands share a sign that the raw sum lost.
    ovf = (a[ACC_WIDTH-1] == b[ACC_WIDTH-1]) && (raw[ACC_WIDTH-1] != a[ACC_WIDTH-1]);
`ifdef STRIPES_ACC_SAT_EN
    if (ovf) begin
      sum = a[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end else begin
      sum = raw;
    end
`else
    sum = raw;
`endif
  end

endmodule

// File: rtl/stripes_column_accumulator.sv
// Accumulates W_BITS shifted column partial sums (MSB column first) into one dot product.
// Optional macro STRIPES_ACC_SAT_EN: saturating adds plus a sticky sat_flag output.
module stripes_column_accumulator
  import stripes_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int PSUM_WIDTH = DATA_WIDTH + 10,
  parameter int ACC_WIDTH  = DATA_WIDTH + 16,
  parameter int W_BITS     = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [PSUM_WIDTH-1:0] psum_in,
  input  logic        [2:0]            column_idx,
  input  logic                         is_msb,
  input  logic                         load_accum,
  input  logic signed [ACC_WIDTH-1:0]  accum_prev,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [ACC_WIDTH-1:0]  result,
  output logic                         seq_err
`ifdef STRIPES_ACC_SAT_EN
  ,
  output logic                         sat_flag
`endif
);

  localparam logic [2:0] COL_FIRST  = 3'(W_BITS - 1);
  localparam logic [2:0] COL_SECOND = 3'(W_BITS - 2);

  state_e                      state_q, state_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic signed [ACC_WIDTH-1:0] result_q, result_d;
  logic        [2:0]           exp_col_q, exp_col_d;
  logic                        out_valid_q, out_valid_d;
  logic                        seq_err_q, seq_err_d;
  logic signed [ACC_WIDTH-1:0] add_a, add_sum, psum_sext;
  logic                        add_ovf, accept, first_ok, cont_ok;
`ifdef STRIPES_ACC_SAT_EN
  logic                        sat_q, sat_d;
`else
  logic                        unused_ovf;
  assign unused_ovf = add_ovf;
`endif

  // Only the completing beat stalls, and only while an untaken result is held.
  assign in_ready = !(out_valid_q && !out_ready && (state_q == ACCUM) && (exp_col_q == 3'd0));
  assign accept   = in_valid && in_ready;
  assign first_ok = (column_idx == COL_FIRST) && is_msb;
  assign cont_ok  = (state_q == ACCUM) && (column_idx == exp_col_q) && !is_msb;

  assign psum_sext = ACC_WIDTH'(sext({{(64-PSUM_WIDTH){1'b0}}, psum_in}, PSUM_WIDTH));
  assign add_a     = cont_ok ? acc_q : (load_accum ? accum_prev : '0);

  stripes_acc_add #(.ACC_WIDTH(ACC_WIDTH)) u_add (
    .a   (add_a),
    .b   (psum_sext),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    exp_col_d   = exp_col_q;
    result_d    = result_q;
    out_valid_d = out_valid_q && !out_ready;
    seq_err_d   = 1'b0;
`ifdef STRIPES_ACC_SAT_EN
    sat_d       = sat_q;
`endif
    if (accept) begin
      if (cont_ok) begin
        acc_d = add_sum;
`ifdef STRIPES_ACC_SAT_EN
        sat_d = sat_q | add_ovf;
`endif
        if (exp_col_q == 3'd0) begin
          result_d    = add_sum;
          out_valid_d = 1'b1;
          state_d     = IDLE;
          exp_col_d   = COL_FIRST;
        end else begin
          exp_col_d = exp_col_q - 3'd1;
        end
      end else begin
        // A first beat arriving mid-group is still an error but restarts at once.
        seq_err_d = (state_q == ACCUM) || !first_ok;
        if (first_ok) begin
          acc_d     = add_sum;
          exp_col_d = COL_SECOND;
          state_d   = ACCUM;
`ifdef STRIPES_ACC_SAT_EN
          sat_d     = add_ovf;
`endif
        end else begin
          state_d   = IDLE;
          exp_col_d = COL_FIRST;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      exp_col_q   <= COL_FIRST;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      seq_err_q   <= 1'b0;
`ifdef STRIPES_ACC_SAT_EN
      sat_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      exp_col_q   <= exp_col_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      seq_err_q   <= seq_err_d;
`ifdef STRIPES_ACC_SAT_EN
      sat_q       <= sat_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign seq_err   = seq_err_q;
`ifdef STRIPES_ACC_SAT_EN
  assign sat_flag  = sat_q;
`endif

endmodule

// File: tb/tb_stripes_column_accumulator.sv
// Self-checking bench for stripes_column_accumulator: vector table, directed corner sequences, random vs. model.
module tb_stripes_column_accumulator;

  localparam int AW = 24;
  localparam int PW = 18;
  localparam longint ACC_MAX = (64'sd1 <<< (AW - 1)) - 1;
  localparam longint ACC_MIN = -(64'sd1 <<< (AW - 1));

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [PW-1:0] psum_in = '0;
  logic        [2:0]    column_idx = '0;
  logic                 is_msb = 1'b0;
  logic                 load_accum = 1'b0;
  logic signed [AW-1:0] accum_prev = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic signed [AW-1:0] result;
  logic                 seq_err;
`ifdef STRIPES_ACC_SAT_EN
  logic                 sat_flag;
`endif

  always #5 clk = ~clk;

  stripes_column_accumulator dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .psum_in    (psum_in),
    .column_idx (column_idx),
    .is_msb     (is_msb),
    .load_accum (load_accum),
    .accum_prev (accum_prev),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .seq_err    (seq_err)
`ifdef STRIPES_ACC_SAT_EN
    ,
    .sat_flag   (sat_flag)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic set_in(input logic v, input int col, input logic msb, input int ps,
                        input logic ld, input int prev, input logic ordy);
    in_valid   = v;
    column_idx = col[2:0];
    is_msb     = msb;
    psum_in    = ps[PW-1:0];
    load_accum = ld;
    accum_prev = prev[AW-1:0];
    out_ready  = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int col, input logic msb, input int ps, input logic ld,
                      input int prev, input logic ordy);
    set_in(1'b1, col, msb, ps, ld, prev, ordy);
    tick();
  endtask

  task automatic idle(input logic ordy);
    set_in(1'b0, 0, 1'b0, 0, 1'b0, 0, ordy);
    tick();
  endtask

  // Weight 8'b1000_0011 times activation 10, one beat per column 7..0.
  function automatic int tp_psum(input int c);
    return (c == 7) ? -1280 : (c == 1) ? 20 : (c == 0) ? 10 : 0;
  endfunction

  task automatic run_group(input logic ld, input int prev, input logic ordy);
    for (int c = 7; c >= 0; c--) beat(c, c == 7, tp_psum(c), ld, prev, ordy);
  endtask

  typedef struct {
    int   col;
    logic msb;
    int   psum;
    logic ld;
    int   prev;
    logic ordy;
    logic e_rdy;
    logic e_ov;
    int   e_res;
    logic e_err;
  } vec_t;

  vec_t tbl[$];

  // Reference model: group bookkeeping with a queue of accepted column sums.
  bit     m_ingrp, m_ov, m_err, m_sat;
  int     m_exp;
  longint m_seed, m_res;
  longint m_q[$];

  function automatic longint wrap_acc(input longint x);
    logic signed [AW-1:0] w;
    w = x[AW-1:0];
    return longint'(w);
  endfunction

  function automatic void fold(input longint seed, input longint q[$], output longint tot, output bit sat);
    longint t;
    tot = seed;
    sat = 1'b0;
    foreach (q[i]) begin
      t = tot + q[i];
`ifdef STRIPES_ACC_SAT_EN
      if (t > ACC_MAX) begin t = ACC_MAX; sat = 1'b1; end
      if (t < ACC_MIN) begin t = ACC_MIN; sat = 1'b1; end
`else
      t = wrap_acc(t);
`endif
      tot = t;
    end
  endfunction

  initial begin
    vec_t   v;
    longint tot;
    bit     s;
    int     r_col, r_ps, r_prev, tmp;
    bit     r_msb, r_ld, r_v, r_ordy, have_beat, m_rdy, n_ov, first;
    int     gen_col;

    // Reset state
    set_in(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b1);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_seq_err", seq_err, 0);
    check("rst_in_ready", in_ready, 1);
`ifdef STRIPES_ACC_SAT_EN
    check("rst_sat_flag", sat_flag, 0);
`endif
    reset = 1'b1;
    tick();

    // Two back-to-back groups: plain, then seeded with 1000
    for (int g = 0; g < 2; g++) begin
      for (int c = 7; c >= 0; c--) begin
        v.col = c; v.msb = (c == 7); v.psum = tp_psum(c); v.ld = (g == 1); v.prev = 1000;
        v.ordy = 1'b1; v.e_rdy = 1'b1; v.e_ov = (c == 0); v.e_err = 1'b0;
        v.e_res = (g == 0) ? ((c == 0) ? -1250 : 0) : ((c == 0) ? -250 : -1250);
        tbl.push_back(v);
      end
    end
    foreach (tbl[i]) begin
      set_in(1'b1, tbl[i].col, tbl[i].msb, tbl[i].psum, tbl[i].ld, tbl[i].prev, tbl[i].ordy);
      #1;
      check($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].e_rdy);
      tick();
      check($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].e_ov);
      check($sformatf("tbl%0d_result", i), result, tbl[i].e_res);
      check($sformatf("tbl%0d_seq_err", i), seq_err, tbl[i].e_err);
    end
    idle(1'b1);
    check("tbl_out_valid_drop", out_valid, 0);

    // Held result stalls only the second group's col-0 beat
    run_group(1'b0, 0, 1'b0);
    check("stall_a_valid", out_valid, 1);
    check("stall_a_result", result, -1250);
    for (int c = 7; c >= 1; c--) begin
      set_in(1'b1, c, c == 7, tp_psum(c), 1'b1, 1000, 1'b0);
      #1;
      check($sformatf("stall_b%0d_in_ready", c), in_ready, 1);
      tick();
    end
    check("stall_hold_result", result, -1250);
    set_in(1'b1, 0, 1'b0, 10, 1'b0, 0, 1'b0);
    #1;
    check("stall_col0_in_ready", in_ready, 0);
    tick();
    check("stall_col0_valid", out_valid, 1);
    check("stall_col0_result", result, -1250);
    set_in(1'b1, 0, 1'b0, 10, 1'b0, 0, 1'b1);
    #1;
    check("stall_release_in_ready", in_ready, 1);
    tick();
    check("stall_b_valid", out_valid, 1);
    check("stall_b_result", result, -250);
    idle(1'b1);
    check("stall_b_taken", out_valid, 0);

    // Out-of-order column
    beat(7, 1'b1, 500, 1'b0, 0, 1'b1);
    beat(5, 1'b0, 40, 1'b0, 0, 1'b1);
    check("skip_seq_err", seq_err, 1);
    check("skip_out_valid", out_valid, 0);
    idle(1'b1);
    check("skip_err_pulse", seq_err, 0);
    check("skip_no_output", out_valid, 0);

    // New first beat mid-group restarts the group
    beat(7, 1'b1, 777, 1'b0, 0, 1'b1);
    beat(6, 1'b0, 3, 1'b0, 0, 1'b1);
    beat(5, 1'b0, 4, 1'b0, 0, 1'b1);
    beat(7, 1'b1, -1280, 1'b0, 0, 1'b1);
    check("restart_seq_err", seq_err, 1);
    for (int c = 6; c >= 0; c--) beat(c, 1'b0, tp_psum(c), 1'b0, 0, 1'b1);
    check("restart_valid", out_valid, 1);
    check("restart_result", result, -1250);
    check("restart_no_err", seq_err, 0);
    idle(1'b1);

    // Asynchronous reset in the middle of a group, with a result being held
    beat(7, 1'b1, -1280, 1'b0, 0, 1'b1);
    for (int c = 6; c >= 0; c--) beat(c, 1'b0, (c == 0) ? 90 : 0, 1'b0, 0, 1'b0);
    check("rstmid_pre_result", result, -1190);
    for (int c = 7; c >= 3; c--) beat(c, c == 7, tp_psum(c), 1'b0, 0, 1'b0);
    set_in(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b1);
    #1 reset = 1'b0;
    #1;
    check("rstmid_out_valid", out_valid, 0);
    check("rstmid_result", result, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    beat(7, 1'b1, -1280, 1'b0, 0, 1'b1);
    check("rstmid_first_ok", seq_err, 0);
    for (int c = 6; c >= 0; c--) beat(c, 1'b0, tp_psum(c), 1'b0, 0, 1'b1);
    check("rstmid_valid", out_valid, 1);
    check("rstmid_after_result", result, -1250);
    idle(1'b1);

    // Seed near the positive limit
    beat(7, 1'b1, 1000, 1'b1, 8388508, 1'b1);
    for (int c = 6; c >= 0; c--) beat(c, 1'b0, 0, 1'b0, 0, 1'b1);
    check("ovf_valid", out_valid, 1);
`ifdef STRIPES_ACC_SAT_EN
    check("ovf_result", result, 8388607);
    check("ovf_sat_flag", sat_flag, 1);
`else
    check("ovf_result", result, -8387708);
`endif
    idle(1'b1);

    // Randomized traffic against the model
    set_in(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b1);
    #1 reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    tick();
    m_ingrp = 0; m_ov = 0; m_err = 0; m_sat = 0; m_exp = 7; m_seed = 0; m_res = 0;
    m_q = {};
    have_beat = 0;
    gen_col = 7;
    r_col = 0; r_msb = 0; r_ps = 0; r_ld = 0; r_prev = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      r_v    = ($urandom_range(0, 9) != 0);
      r_ordy = ($urandom_range(0, 3) != 0);
      if (!have_beat) begin
        if ($urandom_range(0, 19) == 0) begin
          r_col = $urandom_range(0, 7);
          r_msb = $urandom_range(0, 1);
        end else begin
          r_col = gen_col;
          r_msb = (gen_col == 7);
        end
        tmp    = $urandom_range(0, 262143);
        r_ps   = tmp - 131072;
        tmp    = $urandom_range(0, 16777215);
        r_prev = tmp - 8388608;
        r_ld   = $urandom_range(0, 1);
        have_beat = 1;
      end
      set_in(r_v, r_col, r_msb, r_ps, r_ld, r_prev, r_ordy);
      #1;
      m_rdy = !(m_ov && !r_ordy && m_ingrp && m_exp == 0);
      check("rnd_in_ready", in_ready, m_rdy);
      n_ov  = m_ov && !r_ordy;
      m_err = 0;
      if (r_v && m_rdy) begin
        first = (r_col == 7) && r_msb;
        if (m_ingrp && r_col == m_exp && !r_msb) begin
          m_q.push_back(r_ps);
          fold(m_seed, m_q, tot, s);
          m_sat = s;
          if (m_exp == 0) begin
            m_res   = tot;
            n_ov    = 1;
            m_ingrp = 0;
          end else begin
            m_exp--;
          end
        end else begin
          m_err = m_ingrp || !first;
          if (first) begin
            m_ingrp = 1;
            m_exp   = 6;
            m_seed  = r_ld ? longint'(r_prev) : 0;
            m_q     = {};
            m_q.push_back(r_ps);
            fold(m_seed, m_q, tot, s);
            m_sat = s;
          end else begin
            m_ingrp = 0;
          end
        end
        have_beat = 0;
        gen_col   = m_ingrp ? m_exp : 7;
      end
      m_ov = n_ov;
      tick();
      check("rnd_out_valid", out_valid, m_ov);
      check("rnd_result", result, m_res);
      check("rnd_seq_err", seq_err, m_err);
`ifdef STRIPES_ACC_SAT_EN
      check("rnd_sat_flag", sat_flag, m_sat);
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
